stream_nasti_mover_sched: RTL

//  Round-robin command scheduler in front of the stream-to-NASTI data mover.

---
 rtl/stream_nasti_mover_sched.sv | 90 +++++++++
 1 files changed

// File: rtl/stream_nasti_mover_sched.sv
// stream_nasti_mover_sched: round-robin scheduler issuing DMA write commands to the stream-to-NASTI mover.
module stream_nasti_mover_sched #(
  parameter int NUM_REQ        = 4,
  parameter int ADDR_WIDTH     = 64,
  parameter int DATA_WIDTH     = 64,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic                          aclk,
  input  logic                          areset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_len,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ-1:0]            req_en,
  output logic [NUM_REQ-1:0]            done,
  output logic                          m_valid,
  output logic [ADDR_WIDTH-1:0]         m_addr,
  output logic [ADDR_WIDTH-1:0]         m_len,
  input  logic                          m_ready,
  output logic [$clog2(NUM_REQ)-1:0]    src_sel,
  output logic                          busy,
  output logic [31:0]                   xfer_cnt,
  output logic                          timeout_err,
  input  logic                          err_clr
);
  localparam int SW    = $clog2(NUM_REQ);
  localparam int SHIFT = $clog2(DATA_WIDTH / 8);
  localparam int TW    = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [ADDR_WIDTH-1:0] MASK = {ADDR_WIDTH{1'b1}} << SHIFT;
  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;
  state_t state, nxt;
  logic [SW-1:0] last, win;
  logic [NUM_REQ-1:0] cand;
  logic [ADDR_WIDTH-1:0] w_addr, w_len;
  logic [TW-1:0] tcnt;
  logic hit, accept, tmo;
  assign cand   = req_valid & req_en;
  assign w_addr = req_addr[win*ADDR_WIDTH +: ADDR_WIDTH] & MASK;
  assign w_len  = req_len[win*ADDR_WIDTH +: ADDR_WIDTH] & MASK;
  assign accept = state == IDLE && hit;
  assign tmo    = TIMEOUT_CYCLES != 0 && state == ISSUE && tcnt == TW'(TIMEOUT_CYCLES - 1);
  // Scanning downward lets the nearest requester after last overwrite the farther ones.
  always_comb begin
    logic [SW-1:0] j;
    j   = '0;
    win = last;
    hit = 1'b0;
    for (int i = NUM_REQ; i >= 1; i--) begin
      j = SW'((int'(last) + i) % NUM_REQ);
      if (cand[j]) begin
        win = j;
        hit = 1'b1;
      end
    end
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) state <= IDLE;
    else state <= nxt;
  always_comb
    nxt = state == IDLE  ? (hit ? (w_len == '0 ? DONE : ISSUE) : IDLE) :
          state == ISSUE ? (m_ready ? DONE : ISSUE) : IDLE;
  always_comb begin
    m_valid   = state == ISSUE;
    busy      = state != IDLE;
    done      = state == DONE ? NUM_REQ'(1) << src_sel : '0;
    req_ready = accept ? NUM_REQ'(1) << win : '0;
  end
  always_ff @(posedge aclk or posedge areset)
    if (areset) begin
      m_addr      <= '0;
      m_len       <= '0;
      src_sel     <= '0;
      xfer_cnt    <= '0;
      timeout_err <= 1'b0;
      tcnt        <= '0;
      last        <= SW'(NUM_REQ - 1);
    end else begin
      if (accept) begin
        m_addr  <= w_addr;
        m_len   <= w_len;
        src_sel <= win;
      end
      if (state == DONE) begin
        xfer_cnt <= xfer_cnt + 1;
        last     <= src_sel;
      end
      tcnt        <= state != ISSUE ? '0 : tcnt == TW'(TIMEOUT_CYCLES) ? tcnt : tcnt + 1'b1;
      timeout_err <= tmo | (timeout_err & ~err_clr);
    end
endmodule
